// File: rtl/phy_free_list.sv
// rtl/phy_free_list.sv - circular FIFO of free physical register tags
module phy_free_list #(
  parameter int PHY_NUM   = 64,
  parameter int ARCH_NUM  = 32,
  parameter int PHY_SEL   = 6,
  parameter int DEPTH     = 32,
  parameter int DEPTH_SEL = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_req_1,
  input  logic                 alloc_req_2,
  input  logic                 stall_DP,
  output logic [PHY_SEL-1:0]   alloc_tag_1,
  output logic [PHY_SEL-1:0]   alloc_tag_2,
  output logic                 allocatable,
  input  logic                 release_valid_1,
  input  logic                 release_valid_2,
  input  logic [PHY_SEL-1:0]   release_tag_1,
  input  logic [PHY_SEL-1:0]   release_tag_2,
  output logic [DEPTH_SEL:0]   free_count,
  output logic                 overflow_err
);

  // Tags ARCH_NUM..PHY_NUM-1 are free at reset; ARCH_NUM always lies inside the tag space.
  localparam int FIRST_FREE = ARCH_NUM % PHY_NUM;

  logic [PHY_SEL-1:0]   entry_q [DEPTH];
  logic [PHY_SEL-1:0]   entry_d [DEPTH];
  logic [DEPTH_SEL-1:0] head_q, head_d, tail_q, tail_d, head_plus1;
  logic [DEPTH_SEL:0]   free_q, free_d;
  logic                 ovf_q, ovf_d;
  logic [1:0]           reqnum, popnum;
  logic [DEPTH_SEL+1:0] base, room, accsum;
  logic                 acc_1, acc_2;

  always_comb begin
    reqnum      = alloc_req_1 ? (alloc_req_2 ? 2'd2 : 2'd1) : 2'd0;
    allocatable = (free_q >= (DEPTH_SEL+1)'(reqnum));
    popnum      = (allocatable && !stall_DP) ? reqnum : 2'd0;
    head_plus1  = head_q + DEPTH_SEL'(1);
    alloc_tag_1 = entry_q[head_q];
    alloc_tag_2 = entry_q[head_plus1];

    // Releases are accepted only while there is room after this cycle's pop; slot 2 is dropped first.
    base   = (DEPTH_SEL+2)'(free_q) - (DEPTH_SEL+2)'(popnum);
    room   = (DEPTH_SEL+2)'(DEPTH) - base;
    acc_1  = release_valid_1 && (room != '0);
    acc_2  = release_valid_2 && (room > (DEPTH_SEL+2)'(acc_1));
    accsum = base + (DEPTH_SEL+2)'(acc_1) + (DEPTH_SEL+2)'(acc_2);

    entry_d = entry_q;
    if (acc_1) entry_d[tail_q] = release_tag_1;
    if (acc_2) entry_d[tail_q + DEPTH_SEL'(acc_1)] = release_tag_2;

    head_d = head_q + DEPTH_SEL'(popnum);
    tail_d = tail_q + DEPTH_SEL'(acc_1) + DEPTH_SEL'(acc_2);
    free_d = accsum[DEPTH_SEL:0];
    ovf_d  = ovf_q | (release_valid_1 & ~acc_1) | (release_valid_2 & ~acc_2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= PHY_SEL'(FIRST_FREE + i);
      end
      head_q <= '0;
      tail_q <= '0;
      free_q <= (DEPTH_SEL+1)'(DEPTH);
      ovf_q  <= 1'b0;
    end else begin
      entry_q <= entry_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      free_q  <= free_d;
      ovf_q   <= ovf_d;
    end
  end

  assign free_count   = free_q;
  assign overflow_err = ovf_q;

endmodule
